ram_write_buffer: RTL and testbench

- Write-side counterpart to the fetch/decode/execute read path.
  - The read path muxes an address into the ram each FDE phase and reads data out.
  - This block accepts write requests from execute-stage logic and queues them in a small FIFO.
  - It drains one entry into the ram per execute phase, owning the ram address and write-enable only in that slot.
- Sits between the execute datapath and the ram. Takes over the ram address mux via mem_owner.

---
 rtl/ram_write_buffer_if.sv | 25 ++
 rtl/ram_write_buffer.sv | 65 ++++++
 tb/tb_ram_write_buffer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/ram_write_buffer_if.sv
// ram_write_buffer_if: execute-stage write requests in, ram write port and address ownership out.
interface ram_write_buffer_if #(
    parameter int ADDRESS_BITS = 5,
    parameter int DATA_BITS    = 8
);
    logic                    fde_execute;
    logic                    req_valid;
    logic [ADDRESS_BITS-1:0] req_address;
    logic [DATA_BITS-1:0]    req_data;
    logic                    req_ready;
    logic                    ram_w_enable;
    logic [ADDRESS_BITS-1:0] ram_address;
    logic [DATA_BITS-1:0]    ram_data_in;
    logic                    mem_owner;

    modport master (
        output fde_execute, req_valid, req_address, req_data,
        input  req_ready, ram_w_enable, ram_address, ram_data_in, mem_owner
    );

    modport slave (
        input  fde_execute, req_valid, req_address, req_data,
        output req_ready, ram_w_enable, ram_address, ram_data_in, mem_owner
    );
endinterface

// File: rtl/ram_write_buffer.sv
// ram_write_buffer: small FIFO of ram writes, drained one entry per execute slot while owning the ram address.
module ram_write_buffer #(
    parameter int ADDRESS_BITS = 5,
    parameter int DATA_BITS    = 8,
    parameter int DEPTH_LOG2   = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    ram_write_buffer_if.slave   bus,
    output logic [DEPTH_LOG2:0] count,
    output logic [15:0]         writes_done
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int EW    = ADDRESS_BITS + DATA_BITS;

    logic [EW-1:0]         mem_q [DEPTH];
    logic [EW-1:0]         mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [15:0]           writes_done_q, writes_done_d;
    logic [EW-1:0]         head;
    logic                  push;
    logic                  drain;

    // Ready looks only at the registered count, so a full buffer refuses even when it pops that cycle.
    assign bus.req_ready    = count_q != (DEPTH_LOG2+1)'(DEPTH);
    assign push             = bus.req_valid && bus.req_ready;
    assign drain            = bus.fde_execute && count_q != '0;
    assign head             = mem_q[rd_ptr_q];
    assign bus.ram_w_enable = drain;
    assign bus.mem_owner    = drain;
    assign bus.ram_address  = drain ? head[EW-1:DATA_BITS] : '0;
    assign bus.ram_data_in  = drain ? head[DATA_BITS-1:0] : '0;
    assign count            = count_q;
    assign writes_done      = writes_done_q;

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = {bus.req_address, bus.req_data};
        wr_ptr_d      = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d      = drain ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d       = count_q + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(drain);
        writes_done_d = writes_done_q + 16'(drain);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            writes_done_q <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            writes_done_q <= writes_done_d;
        end
    end

    // Storage needs no reset; entries are only read once count says they are valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_ram_write_buffer.sv
// tb_ram_write_buffer: table vectors, corner sequences and random traffic against a queue-based model.
module tb_ram_write_buffer;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  count;
    logic [15:0] writes_done;

    ram_write_buffer_if #(.ADDRESS_BITS(5), .DATA_BITS(8)) bus ();

    ram_write_buffer #(.ADDRESS_BITS(5), .DATA_BITS(8), .DEPTH_LOG2(2)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus),
        .count(count),
        .writes_done(writes_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       fde;
        logic       v;
        logic [4:0] a;
        logic [7:0] d;
        logic       rdy;
        logic       wen;
        logic [4:0] ea;
        logic [7:0] ed;
        logic [2:0] cnt;
    } vec_t;

    typedef struct {
        logic [4:0] a;
        logic [7:0] d;
    } ent_t;

    ent_t       q[$];
    logic [7:0] ram [32];
    logic [7:0] ram_ref [32];
    int         writes;
    int         n_vec;
    int         n_err;
    vec_t       tbl [24];

    function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", n, act, exp);
        end
    endfunction

    function automatic vec_t mk(int fde, int v, int a, int d, int rdy, int wen, int ea, int ed, int cnt);
        vec_t r;
        r.fde = fde[0];
        r.v   = v[0];
        r.a   = a[4:0];
        r.d   = d[7:0];
        r.rdy = rdy[0];
        r.wen = wen[0];
        r.ea  = ea[4:0];
        r.ed  = ed[7:0];
        r.cnt = cnt[2:0];
        return r;
    endfunction

    // One clock: drive on the falling edge, check against the model, then let the ram sample.
    task automatic step(input vec_t t, input bit use_tbl);
        logic       rdy, drain, wen_s;
        logic [4:0] ea, a_s;
        logic [7:0] ed, d_s;
        @(negedge clk);
        bus.fde_execute = t.fde;
        bus.req_valid   = t.v;
        bus.req_address = t.a;
        bus.req_data    = t.d;
        #1;
        rdy   = q.size() != 4;
        drain = t.fde && q.size() != 0;
        ea    = '0;
        ed    = '0;
        if (drain) begin
            ea = q[0].a;
            ed = q[0].d;
        end
        chk("req_ready", 32'(bus.req_ready), 32'(rdy));
        chk("ram_w_enable", 32'(bus.ram_w_enable), 32'(drain));
        chk("mem_owner", 32'(bus.mem_owner), 32'(drain));
        chk("ram_address", 32'(bus.ram_address), 32'(ea));
        chk("ram_data_in", 32'(bus.ram_data_in), 32'(ed));
        chk("count", 32'(count), 32'(q.size()));
        chk("writes_done", 32'(writes_done), writes & 32'hFFFF);
        if (use_tbl) begin
            chk("tbl_ready", 32'(bus.req_ready), 32'(t.rdy));
            chk("tbl_w_enable", 32'(bus.ram_w_enable), 32'(t.wen));
            chk("tbl_address", 32'(bus.ram_address), 32'(t.ea));
            chk("tbl_data", 32'(bus.ram_data_in), 32'(t.ed));
            chk("tbl_count", 32'(count), 32'(t.cnt));
        end
        wen_s = bus.ram_w_enable;
        a_s   = bus.ram_address;
        d_s   = bus.ram_data_in;
        if (drain) begin
            ram_ref[ea] = ed;
            void'(q.pop_front());
            writes++;
        end
        if (t.v && rdy) q.push_back('{t.a, t.d});
        @(posedge clk);
        if (wen_s === 1'b1) ram[a_s] = d_s;
    endtask

    initial begin
        vec_t       r;
        logic [4:0] rd;
        logic [7:0] exp_ram [8];
        n_vec  = 0;
        n_err  = 0;
        writes = 0;
        for (int i = 0; i < 32; i++) begin
            ram[i]     = '0;
            ram_ref[i] = '0;
        end
        bus.fde_execute = 1'b1;
        bus.req_valid   = 1'b0;
        bus.req_address = '0;
        bus.req_data    = '0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_ready", 32'(bus.req_ready), 1);
        chk("rst_w_enable", 32'(bus.ram_w_enable), 0);
        chk("rst_owner", 32'(bus.mem_owner), 0);
        chk("rst_address", 32'(bus.ram_address), 0);
        chk("rst_data", 32'(bus.ram_data_in), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_writes", 32'(writes_done), 0);
        @(negedge clk);
        bus.fde_execute = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        tbl[0]  = mk(0, 1, 3, 'hA5, 1, 0, 0, 0,    0);
        tbl[1]  = mk(1, 0, 0, 0,    1, 1, 3, 'hA5, 1);
        tbl[2]  = mk(0, 0, 0, 0,    1, 0, 0, 0,    0);
        tbl[3]  = mk(0, 1, 0, 20,   1, 0, 0, 0,    0);
        tbl[4]  = mk(0, 1, 1, 21,   1, 0, 0, 0,    1);
        tbl[5]  = mk(0, 1, 2, 22,   1, 0, 0, 0,    2);
        tbl[6]  = mk(0, 1, 3, 23,   1, 0, 0, 0,    3);
        tbl[7]  = mk(0, 1, 4, 24,   0, 0, 0, 0,    4);
        tbl[8]  = mk(0, 1, 4, 24,   0, 0, 0, 0,    4);
        tbl[9]  = mk(1, 1, 4, 24,   0, 1, 0, 20,   4);
        tbl[10] = mk(0, 1, 4, 24,   1, 0, 0, 0,    3);
        tbl[11] = mk(1, 0, 0, 0,    0, 1, 1, 21,   4);
        tbl[12] = mk(1, 0, 0, 0,    1, 1, 2, 22,   3);
        tbl[13] = mk(1, 0, 0, 0,    1, 1, 3, 23,   2);
        tbl[14] = mk(1, 0, 0, 0,    1, 1, 4, 24,   1);
        tbl[15] = mk(1, 0, 0, 0,    1, 0, 0, 0,    0);
        tbl[16] = mk(0, 1, 5, 'h50, 1, 0, 0, 0,    0);
        tbl[17] = mk(0, 1, 6, 'h51, 1, 0, 0, 0,    1);
        tbl[18] = mk(1, 1, 7, 'h77, 1, 1, 5, 'h50, 2);
        tbl[19] = mk(1, 1, 7, 'h77, 1, 1, 6, 'h51, 2);
        tbl[20] = mk(1, 1, 7, 'h77, 1, 1, 7, 'h77, 2);
        tbl[21] = mk(1, 0, 0, 0,    1, 1, 7, 'h77, 2);
        tbl[22] = mk(1, 0, 0, 0,    1, 1, 7, 'h77, 1);
        tbl[23] = mk(1, 0, 0, 0,    1, 0, 0, 0,    0);

        for (int i = 0; i < 24; i++) begin
            step(tbl[i], 1'b1);
            if (i == 2) begin
                #1;
                rd = bus.mem_owner ? bus.ram_address : 5'd3;
                chk("readback_3", 32'(ram[rd]), 'hA5);
                chk("writes_after_1", 32'(writes_done), 1);
            end
        end
        exp_ram = '{8'd20, 8'd21, 8'd22, 8'd23, 8'd24, 8'h50, 8'h51, 8'h77};
        for (int i = 0; i < 8; i++) chk("ram_order", 32'(ram[i]), 32'(exp_ram[i]));

        // Reset between edges with three entries queued and the write slot open.
        for (int i = 0; i < 3; i++) step(mk(0, 1, 10 + i, 'h30 + i, 0, 0, 0, 0, 0), 1'b0);
        @(negedge clk);
        bus.fde_execute = 1'b1;
        bus.req_valid   = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_count", 32'(count), 0);
        chk("midrst_w_enable", 32'(bus.ram_w_enable), 0);
        chk("midrst_owner", 32'(bus.mem_owner), 0);
        chk("midrst_ready", 32'(bus.req_ready), 1);
        q.delete();
        writes = 0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        for (int i = 10; i < 13; i++) chk("no_write_after_rst", 32'(ram[i]), 32'(ram_ref[i]));

        // Empty buffer through full fetch/decode/execute rounds: the read mux keeps the address.
        for (int i = 0; i < 4; i++) begin
            ram[i]     = 8'(10 + i);
            ram_ref[i] = 8'(10 + i);
        end
        for (int i = 0; i < 12; i++) begin
            step(mk(i % 3 == 2 ? 1 : 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
            #1;
            rd = bus.mem_owner ? bus.ram_address : 5'(i % 4);
            chk("idle_read", 32'(ram[rd]), 32'(10 + i % 4));
        end

        for (int i = 0; i < 400; i++) begin
            r = mk($urandom_range(0, 2) == 2 ? 1 : 0, int'($urandom_range(0, 1)),
                   int'($urandom_range(0, 31)), int'($urandom_range(0, 255)), 0, 0, 0, 0, 0);
            step(r, 1'b0);
        end
        for (int i = 0; i < 6; i++) step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        for (int i = 0; i < 32; i++) chk("ram_final", 32'(ram[i]), 32'(ram_ref[i]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
